// File: rtl/ahb_m2s_arb_mux.sv
// ahb_m2s_arb_mux: AHB multi-master arbiter with burst-locked grant and address/data-phase muxing
module ahb_m2s_arb_mux #(
  parameter int HMST_NUM = 4,
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int HBURST_WIDTH = 3,
  parameter int ARB_MODE = 0,
  localparam int GNT_W = $clog2(HMST_NUM)
) (
  input  logic                      hclk,
  input  logic                      hrst,
  input  logic [HMST_NUM-1:0]       hbusreq_i,
  input  logic [HADDR_WIDTH-1:0]    haddr_i  [0:HMST_NUM-1],
  input  logic [HBURST_WIDTH-1:0]   hburst_i [0:HMST_NUM-1],
  input  logic [2:0]                hsize_i  [0:HMST_NUM-1],
  input  logic [1:0]                htrans_i [0:HMST_NUM-1],
  input  logic                      hwrite_i [0:HMST_NUM-1],
  input  logic [DATA_WIDTH-1:0]     hwdata_i [0:HMST_NUM-1],
  input  logic [DATA_WIDTH/8-1:0]   hwstrb_i [0:HMST_NUM-1],
  input  logic                      hready_i,
  output logic [HMST_NUM-1:0]       hgrant_o,
  output logic [GNT_W-1:0]          hmaster_o,
  output logic [GNT_W-1:0]          hmaster_d_o,
  output logic [HADDR_WIDTH-1:0]    haddr_o,
  output logic [HBURST_WIDTH-1:0]   hburst_o,
  output logic [2:0]                hsize_o,
  output logic [1:0]                htrans_o,
  output logic                      hwrite_o,
  output logic [DATA_WIDTH-1:0]     hwdata_o,
  output logic [DATA_WIDTH/8-1:0]   hwstrb_o
);
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [HBURST_WIDTH-1:0] B_SINGLE = HBURST_WIDTH'(0), B_INCR = HBURST_WIDTH'(1),
    B_WRAP4 = HBURST_WIDTH'(2), B_WRAP8 = HBURST_WIDTH'(4), B_WRAP16 = HBURST_WIDTH'(6);

  logic [4:0] rem, rem_load, rem_nxt;
  logic [GNT_W-1:0] rr_ptr, win, idx;
  logic found, arb_ok;

  assign haddr_o  = haddr_i[hmaster_o];
  assign hburst_o = hburst_i[hmaster_o];
  assign hsize_o  = hsize_i[hmaster_o];
  assign htrans_o = htrans_i[hmaster_o];
  assign hwrite_o = hwrite_i[hmaster_o];
  assign hwdata_o = hwdata_i[hmaster_d_o];
  assign hwstrb_o = hwstrb_i[hmaster_d_o];

  // Beats remaining after a NONSEQ, and the beat counter's next value
  always_comb begin
    rem_load = hburst_o >= B_WRAP16 ? 5'd15 : hburst_o >= B_WRAP8 ? 5'd7 : hburst_o >= B_WRAP4 ? 5'd3 : 5'd0;
    rem_nxt = htrans_o == T_NONSEQ ? rem_load :
              (htrans_o == T_SEQ && rem != 5'd0) ? rem - 5'd1 :
              htrans_o == T_IDLE ? 5'd0 : rem;
  end

  // Rearbitrate only at a transfer boundary that allows the bus to change hands
  assign arb_ok = hready_i && (htrans_o == T_IDLE ||
                               (htrans_o == T_NONSEQ && hburst_o == B_SINGLE) ||
                               (htrans_o == T_SEQ && rem == 5'd1) ||
                               (hburst_o == B_INCR && htrans_o != T_BUSY && !hbusreq_i[hmaster_o]));

  // Pick the winner: lowest index, or first index after the last winner in round-robin
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < HMST_NUM; k++) begin
      idx = ARB_MODE == 1 ? GNT_W'((int'(rr_ptr) + 1 + k) % HMST_NUM) : GNT_W'(k);
      if (!found && hbusreq_i[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end

  // Grant, owner, data-phase owner and burst state advance only on accepted transfers
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      hgrant_o    <= HMST_NUM'(1);
      hmaster_o   <= '0;
      hmaster_d_o <= '0;
      rem         <= '0;
      rr_ptr      <= GNT_W'(HMST_NUM - 1);
    end else if (hready_i) begin
      hmaster_d_o <= hmaster_o;
      rem         <= rem_nxt;
      if (arb_ok) begin
        hgrant_o  <= HMST_NUM'(1) << win;
        hmaster_o <= win;
        if (ARB_MODE == 1 && found) rr_ptr <= win;
      end
    end
  end
endmodule

// File: tb/tb_ahb_m2s_arb_mux.sv
// tb_ahb_m2s_arb_mux: fixed-priority and round-robin instances checked by directed scenarios and a random reference model
module tb_ahb_m2s_arb_mux;
  localparam int N = 4;
  logic hclk = 1'b0;
  logic hrst = 1'b1;
  logic hready = 1'b1;
  logic [N-1:0] hbusreq;
  logic [31:0] haddr [0:N-1];
  logic [2:0]  hburst [0:N-1];
  logic [2:0]  hsize [0:N-1];
  logic [1:0]  htrans [0:N-1];
  logic        hwrite [0:N-1];
  logic [31:0] hwdata [0:N-1];
  logic [3:0]  hwstrb [0:N-1];
  logic [N-1:0] gnt [2];
  logic [1:0]  mst [2];
  logic [1:0]  mstd [2];
  logic [31:0] addr_o [2];
  logic [2:0]  burst_o [2];
  logic [2:0]  size_o [2];
  logic [1:0]  trans_o [2];
  logic        write_o [2];
  logic [31:0] wdata_o [2];
  logic [3:0]  strb_o [2];
  int cmp = 0;
  int bad = 0;
  int own [2], dn [2], rm [2], ptr [2];

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 2; g++) begin : dut
    ahb_m2s_arb_mux #(.HMST_NUM(N), .ARB_MODE(g)) u (
      .hclk(hclk), .hrst(hrst), .hbusreq_i(hbusreq), .haddr_i(haddr), .hburst_i(hburst),
      .hsize_i(hsize), .htrans_i(htrans), .hwrite_i(hwrite), .hwdata_i(hwdata), .hwstrb_i(hwstrb),
      .hready_i(hready), .hgrant_o(gnt[g]), .hmaster_o(mst[g]), .hmaster_d_o(mstd[g]),
      .haddr_o(addr_o[g]), .hburst_o(burst_o[g]), .hsize_o(size_o[g]), .htrans_o(trans_o[g]),
      .hwrite_o(write_o[g]), .hwdata_o(wdata_o[g]), .hwstrb_o(strb_o[g]));
  end

  function automatic int beats(input logic [2:0] b);
    return b < 3'd2 ? 1 : 2 ** (int'(b) / 2 + 1);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = 0; dn[m] = 0; rm[m] = 0; ptr[m] = N - 1;
    end
  endtask

  // Reference: apply the arbitration rules to the inputs present just before the edge
  task automatic model_edge();
    int t, b, w;
    bit ok;
    if (hrst || !hready) return;
    for (int m = 0; m < 2; m++) begin
      t = int'(htrans[own[m]]);
      b = int'(hburst[own[m]]);
      ok = t == 0 || (t == 2 && b == 0) || (t == 3 && rm[m] == 1) || (b == 1 && t != 1 && !hbusreq[own[m]]);
      dn[m] = own[m];
      rm[m] = t == 2 ? beats(hburst[own[m]]) - 1 : (t == 3 && rm[m] > 0) ? rm[m] - 1 : t == 0 ? 0 : rm[m];
      if (ok) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int i;
          i = m == 0 ? k : (ptr[m] + 1 + k) % N;
          if (w < 0 && hbusreq[i]) w = i;
        end
        own[m] = w < 0 ? 0 : w;
        if (w >= 0) ptr[m] = w;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_all();
    hbusreq = '0;
    for (int i = 0; i < N; i++) begin
      htrans[i] = 2'd0; hburst[i] = 3'd0; hsize[i] = 3'd2; hwrite[i] = 1'b0;
      haddr[i] = 32'h0000_0010 * i; hwdata[i] = 32'hA0A0_0000 + i; hwstrb[i] = 4'hF;
    end
  endtask

  task automatic pulse_reset();
    hrst = 1'b1;
    model_reset();
    step();
    hrst = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    model_reset();
    step();
    step();
    hrst = 1'b0;
    hbusreq = 4'b0100;
    step();
    cmp++;
    if (gnt[0] !== 4'b0100) begin bad++; $display("FAIL pre_reset_grant: got %b want %b", gnt[0], 4'b0100); end
    htrans[2] = 2'd2; hburst[2] = 3'd3;
    step();
    hrst = 1'b1;
    model_reset();
    #2;
    cmp++;
    if ({gnt[0], mst[0], mstd[0]} !== {4'b0001, 2'd0, 2'd0}) begin
      bad++; $display("FAIL reset_state: got gnt=%b m=%0d md=%0d want 0001 0 0", gnt[0], mst[0], mstd[0]);
    end
    cmp++;
    if (addr_o[0] !== haddr[0]) begin bad++; $display("FAIL reset_haddr: got %h want %h", addr_o[0], haddr[0]); end
    cmp++;
    if ({gnt[1], mst[1]} !== {4'b0001, 2'd0}) begin bad++; $display("FAIL reset_rr_state: got gnt=%b m=%0d want 0001 0", gnt[1], mst[1]); end
    step();
    hrst = 1'b0;
  endtask

  task automatic test_fixed_priority();
    idle_all();
    haddr[1] = 32'h100;
    hbusreq = 4'b0110;
    step();
    cmp++;
    if (gnt[0] !== 4'b0010) begin bad++; $display("FAIL fixed_grant: got %b want %b", gnt[0], 4'b0010); end
    htrans[1] = 2'd2; hburst[1] = 3'd0;
    #1;
    cmp++;
    if (addr_o[0] !== 32'h100) begin bad++; $display("FAIL fixed_haddr: got %h want %h", addr_o[0], 32'h100); end
    step();
    cmp++;
    if (gnt[0] !== 4'b0010) begin bad++; $display("FAIL fixed_regrant: got %b want %b", gnt[0], 4'b0010); end
  endtask

  task automatic test_burst_lock();
    idle_all();
    hbusreq = 4'b0010;
    step();
    htrans[1] = 2'd2; hburst[1] = 3'd3; haddr[1] = 32'h1000;
    step();
    cmp++;
    if (gnt[0] !== 4'b0010) begin bad++; $display("FAIL burst_beat1: got %b want %b", gnt[0], 4'b0010); end
    hbusreq = 4'b0011;
    htrans[1] = 2'd3;
    for (int b = 1; b < 4; b++) begin
      haddr[1] = 32'h1000 + 32'(4 * b);
      step();
      cmp++;
      if (gnt[0] !== (b == 3 ? 4'b0001 : 4'b0010)) begin
        bad++; $display("FAIL burst_lock_beat%0d: got %b want %b", b + 1, gnt[0], b == 3 ? 4'b0001 : 4'b0010);
      end
    end
    cmp++;
    if ({mst[0], mstd[0]} !== {2'd0, 2'd1}) begin bad++; $display("FAIL burst_switch_sel: got m=%0d md=%0d want 0 1", mst[0], mstd[0]); end
  endtask

  task automatic test_stall();
    htrans[1] = 2'd0;
    hbusreq = 4'b0001;
    htrans[0] = 2'd2; hburst[0] = 3'd3; haddr[0] = 32'h3000;
    step();
    htrans[0] = 2'd3; haddr[0] = 32'h3004;
    step();
    haddr[0] = 32'h3008;
    hbusreq = 4'b0011;
    hready = 1'b0;
    repeat (3) begin
      step();
      cmp++;
      if ({gnt[0], mst[0], mstd[0]} !== {4'b0001, 2'd0, 2'd0}) begin
        bad++; $display("FAIL stall_hold: got gnt=%b m=%0d md=%0d want 0001 0 0", gnt[0], mst[0], mstd[0]);
      end
    end
    hready = 1'b1;
    step();
    cmp++;
    if (gnt[0] !== 4'b0001) begin bad++; $display("FAIL stall_beat3: got %b want %b", gnt[0], 4'b0001); end
    haddr[0] = 32'h300C;
    hbusreq = 4'b0010;
    step();
    cmp++;
    if ({gnt[0], mst[0]} !== {4'b0010, 2'd1}) begin bad++; $display("FAIL stall_complete: got gnt=%b m=%0d want 0010 1", gnt[0], mst[0]); end
  endtask

  task automatic test_handover();
    idle_all();
    hbusreq = 4'b0100;
    step();
    htrans[2] = 2'd2; hburst[2] = 3'd0; hwrite[2] = 1'b1; haddr[2] = 32'h2000; hwdata[2] = 32'hDEADBEEF;
    htrans[3] = 2'd2; haddr[3] = 32'h4000;
    hbusreq = 4'b1000;
    step();
    cmp++;
    if ({mst[0], mstd[0], addr_o[0], wdata_o[0]} !== {2'd3, 2'd2, 32'h4000, 32'hDEADBEEF}) begin
      bad++; $display("FAIL handover: got m=%0d md=%0d addr=%h wdata=%h want 3 2 00004000 deadbeef", mst[0], mstd[0], addr_o[0], wdata_o[0]);
    end
    hready = 1'b0;
    step();
    cmp++;
    if ({mst[0], mstd[0]} !== {2'd3, 2'd2}) begin bad++; $display("FAIL handover_stall: got m=%0d md=%0d want 3 2", mst[0], mstd[0]); end
    hready = 1'b1;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{1, 2, 3, 0, 1};
    idle_all();
    pulse_reset();
    for (int i = 0; i < N; i++) htrans[i] = 2'd2;
    hbusreq = 4'b0001;
    step();
    hbusreq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      cmp++;
      if ({gnt[1], mst[1]} !== {4'(1 << seq[k]), 2'(seq[k])}) begin
        bad++; $display("FAIL rr_seq%0d: got gnt=%b m=%0d want m=%0d", k, gnt[1], mst[1], seq[k]);
      end
    end
    cmp++;
    if (gnt[0] !== 4'b0001) begin bad++; $display("FAIL fixed_all_req: got %b want %b", gnt[0], 4'b0001); end
  endtask

  task automatic test_random();
    logic [80:0] ex, ac;
    idle_all();
    pulse_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      hbusreq = 4'($urandom);
      hready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < N; i++) begin
        htrans[i] = 2'($urandom_range(0, 3));
        hburst[i] = 3'($urandom_range(0, 7));
        hsize[i] = 3'($urandom);
        hwrite[i] = 1'($urandom);
        haddr[i] = $urandom;
        hwdata[i] = $urandom;
        hwstrb[i] = 4'($urandom);
      end
      step();
      for (int m = 0; m < 2; m++) begin
        ex = {4'(1 << own[m]), 2'(own[m]), 2'(dn[m]), haddr[own[m]], htrans[own[m]], hburst[own[m]], hwdata[dn[m]], hwstrb[dn[m]]};
        ac = {gnt[m], mst[m], mstd[m], addr_o[m], trans_o[m], burst_o[m], wdata_o[m], strb_o[m]};
        cmp++;
        if (ac !== ex) begin bad++; $display("FAIL random_c%0d_mode%0d: got %h want %h", c, m, ac, ex); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_burst_lock();
    test_stall();
    test_handover();
    test_round_robin();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule

// File: doc/ahb_m2s_arb_mux.md
# ahb_m2s_arb_mux

Parametrised AHB master-to-slave arbiter and multiplexer for the shared SoC bus. It arbitrates among `HMST_NUM` requesting masters, with fixed-priority or round-robin selectable by parameter. It holds grant across fixed-length bursts and routes the owner's address-phase and data-phase signals to the slave side, with the data-phase select delayed one accepted transfer behind the address-phase select. It sits between the master ports and the address decoder/slave fabric.

## Interface
- `HMST_NUM`, 4: number of masters (2..16); `GNT_W = $clog2(HMST_NUM)` is local.
- `HADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: write data width; strobe is `DATA_WIDTH/8`.
- `HBURST_WIDTH`, 3: burst field width.
- `ARB_MODE`, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.

Ports:
- `hclk` in 1: bus clock; all state on rising edge.
- `hrst` in 1: reset, asynchronous, active-high.
- `hbusreq_i` in HMST_NUM: per-master bus request.
- `haddr_i[0:HMST_NUM-1]` in HADDR_WIDTH: per-master address.
- `hburst_i[]` in HBURST_WIDTH, `hsize_i[]` in 3, `htrans_i[]` in 2, `hwrite_i[]` in 1: per-master control.
- `hwdata_i[]` in DATA_WIDTH, `hwstrb_i[]` in DATA_WIDTH/8: per-master write data and strobe.
- `hready_i` in 1: slave-side transfer-done.
- `hgrant_o` out HMST_NUM: one-hot grant, registered.
- `hmaster_o` out GNT_W: address-phase owner index.
- `hmaster_d_o` out GNT_W: data-phase owner index.
- `haddr_o`, `hburst_o`, `hsize_o`, `htrans_o`, `hwrite_o` out: muxed by `hmaster_o`.
- `hwdata_o`, `hwstrb_o` out: muxed by `hmaster_d_o`.

## Operation
- Encodings:
  - htrans: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - hburst: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- Beat counter `rem` (5 bits) tracks beats remaining after the current accepted one. It updates only when `hready_i`=1:
  - NONSEQ: load beats-1, i.e. 3/7/15 for the 4/8/16-beat types, 0 for SINGLE/INCR.
  - SEQ with `rem`≠0: decrement.
  - IDLE: clear to 0.
  - BUSY: hold.
- `arb_ok` is asserted when `hready_i`=1 and any of the following holds:
  - muxed htrans is IDLE;
  - NONSEQ with SINGLE;
  - SEQ with `rem`==1;
  - hburst is INCR and the owner's `hbusreq_i` is 0.
- BUSY, or a fixed burst with beats remaining, never gives `arb_ok`.
- Winner selection, evaluated when `arb_ok`:
  - Fixed priority: lowest requesting index wins.
  - Round-robin: first requesting index strictly after `rr_ptr`, wrapping modulo HMST_NUM.
  - No requests: park on master 0.
- On `arb_ok`:
  - `hgrant_o` ← one-hot(winner); `hmaster_o` ← winner.
  - In round-robin mode, `rr_ptr` ← winner when any request was present.
  - If the winner equals the current owner, there is no visible change.
- A granted master starts its NONSEQ in the cycle it sees `hgrant_o[i]`=1.
- Data-phase select: when `hready_i`=1, `hmaster_d_o` ← `hmaster_o`.
- Early burst termination is legal:
  - IDLE releases the bus.
  - NONSEQ mid-burst reloads `rem`, with no rearbitration unless SINGLE.

## Timing
- Reset values:
  - `hgrant_o`=1 (master 0), `hmaster_o`=0, `hmaster_d_o`=0, `rem`=0, `rr_ptr`=HMST_NUM-1.
  - Muxed outputs follow master 0 inputs combinationally.
- Arbitration latency: a request seen at edge N with `arb_ok` gives grant visible after edge N. The new owner's address reaches `haddr_o` in the same cycle.
- Handover: the old owner's write data stays on `hwdata_o` for the cycle after handover, while `haddr_o` already carries the new owner's address.
- `hready_i`=0 freezes everything: `hgrant_o`, `hmaster_o`, `hmaster_d_o`, `rem`, `rr_ptr`.
- Simultaneous request changes while `arb_ok`=0 are ignored until the next `arb_ok`.
- Reset mid-burst immediately returns all state to reset values; no beat completion is required.
- All muxed outputs are purely combinational from the registered selects; there is no added pipeline delay.

## Test plan
- Reset: assert `hrst` mid-traffic → `hgrant_o`=4'b0001, `hmaster_o`=0, `hmaster_d_o`=0; `haddr_o` equals `haddr_i[0]`.
- Fixed priority: bus IDLE, `hbusreq_i`=4'b0110 → after one edge `hgrant_o`=4'b0010; master 1 SINGLE at 0x100 appears on `haddr_o`.
- Burst lock: master 1 runs INCR4 at 0x1000 and master 0 requests from beat 2 → grant held for 4 beats, then switches to master 0 on the edge accepting beat 4 (address 0x100C).
- Stall: `hready_i`=0 for 3 cycles during beat 3 of INCR4 → `hgrant_o`, `hmaster_o`, `hmaster_d_o` and `rem` are unchanged; the burst completes after stall release.
- Round-robin: `ARB_MODE`=1, all four request continuous SINGLEs → grant sequence 1,2,3,0,1.
- Handover alignment: master 2 writes 0xDEADBEEF to 0x2000, then master 3 is granted → in the next cycle `haddr_o`=master 3 address and `hwdata_o`=0xDEADBEEF with `hmaster_d_o`=2.
